// File: rtl/cpu_fpu_addsub_param.sv
// -----------------------------------------------------------------------------
// cpu_fpu_addsub_param
//   Parametrised IEEE-754 binary adder/subtractor for the CPU FPU.
//   Fixed-latency multi-cycle datapath: IDLE -> SPECIAL -> ALIGN -> ADD -> NORM
//   -> ROUND -> PACK -> DONE. Special operands (NaN, inf, zero) skip straight
//   from SPECIAL to DONE. One barrel shifter per stage, no iterative loops.
//
//   Parameters
//     EXP_W  exponent field width (bias = 2**(EXP_W-1)-1)
//     MAN_W  stored fraction width (hidden bit excluded); W = 1+EXP_W+MAN_W
//
//   Ports
//     i_clock    clock, rising edge
//     i_reset_n  asynchronous active-low reset
//     i_request  level request, held until o_ready is seen, then dropped
//     i_sub      1: op1 - op2
//     i_rm       rounding mode (RNE/RTZ/RDN/RUP/RMM; unknown codes act as RNE)
//     i_op1/2    packed operands
//     o_ready    result valid, held while i_request stays high
//     o_result   packed result
//     o_flags    {NV,DZ,OF,UF,NX} for this operation; DZ is always 0
//
//   Build option
//     FPU_ADDSUB_FLUSH_DENORM_EN: subnormal inputs read as signed zero,
//     subnormal results flush to signed zero with UF|NX, NORM never clamps.
//     Undefined (default): full gradual underflow.
// -----------------------------------------------------------------------------
module cpu_fpu_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_request,
  input  logic                   i_sub,
  input  logic [2:0]             i_rm,
  input  logic [EXP_W+MAN_W:0]   i_op1,
  input  logic [EXP_W+MAN_W:0]   i_op2,
  output logic                   o_ready,
  output logic [EXP_W+MAN_W:0]   o_result,
  output logic [4:0]             o_flags
);

`ifdef FPU_ADDSUB_FLUSH_DENORM_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int X    = MAN_W + 4;          // hidden + fraction + G + R + S
  localparam int EW   = EXP_W + 2;          // signed working exponent
  localparam int SH_W = $clog2(X);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 2);
  localparam logic signed [EW-1:0] EMIN = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} rm_t;
  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t state, state_next;
  logic   ready_next;

  // Captured operation; op_b already carries the effective (subtract-adjusted) sign.
  logic [W-1:0] op_a, op_b;
  rm_t          rm_q;

  // Working datapath registers, reused from stage to stage.
  logic                   sign_q, eff_sub_q, zero_q, nx_q;
  logic signed [EW-1:0]   exp_q;
  logic [X:0]             man_q;     // bit X catches the adder carry
  logic [X-1:0]           small_q;
  logic [SH_W-1:0]        shift_q;
  logic [W-1:0]           result_q;
  logic [4:0]             flags_q;
  logic                   ready_q;

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign {sa, ea, fa} = op_a;
  assign {sb, eb, fb} = op_b;
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = (ea == '0) && (FLUSH || (fa == '0));
  assign b_zero = (eb == '0) && (FLUSH || (fb == '0));

  logic          spec_hit, spec_nv;
  logic [W-1:0]  spec_result;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    spec_hit    = 1'b1;
    spec_nv     = 1'b0;
    spec_result = QNAN;
    if (a_nan || b_nan)                    spec_nv = a_snan || b_snan;
    else if (a_inf && b_inf && (sa != sb)) spec_nv = 1'b1;
    else if (a_inf)                        spec_result = op_a;
    else if (b_inf)                        spec_result = op_b;
    else if (a_zero && b_zero)
      spec_result = {(rm_q == RDN) ? (sa | sb) : (sa & sb), {(W-1){1'b0}}};
    else if (a_zero)                       spec_result = op_b;
    else if (b_zero)                       spec_result = op_a;
    else                                   spec_hit = 1'b0;
  end

  // Order operands by magnitude so the subtraction never goes negative.
  logic               swap;
  logic [EXP_W-1:0]   ea_eff, eb_eff, big_exp, exp_diff;
  logic [X-1:0]       big_man, small_man;
  logic [SH_W-1:0]    shift_sat;

  always_comb begin
    swap      = op_b[W-2:0] > op_a[W-2:0];
    ea_eff    = (ea == '0) ? EXP_W'(1) : ea;   // subnormals live at emin
    eb_eff    = (eb == '0) ? EXP_W'(1) : eb;
    big_exp   = swap ? eb_eff : ea_eff;
    exp_diff  = swap ? (eb_eff - ea_eff) : (ea_eff - eb_eff);
    big_man   = swap ? {|eb, fb, 3'b000} : {|ea, fa, 3'b000};
    small_man = swap ? {|ea, fa, 3'b000} : {|eb, fb, 3'b000};
    shift_sat = (int'(exp_diff) > X - 1) ? SH_W'(X - 1) : SH_W'(exp_diff);
  end

  // ---------------------------------------------------------------------------
  // ALIGN / ADD / NORM / ROUND / PACK combinational stage logic
  // ---------------------------------------------------------------------------
  logic [X-1:0] shifted, lost_mask, aligned;
  logic [X:0]   sum;

  always_comb begin
    shifted   = small_q >> shift_q;
    lost_mask = (X'(1) << shift_q) - X'(1);
    // Everything shifted out collapses into the sticky bit.
    aligned   = {shifted[X-1:1], shifted[0] | (|(small_q & lost_mask))};
    sum       = eff_sub_q ? ({1'b0, man_q[X-1:0]} - {1'b0, small_q})
                          : ({1'b0, man_q[X-1:0]} + {1'b0, small_q});
  end

  int                   lz, shl;
  logic [X:0]           norm_man;
  logic signed [EW-1:0] norm_exp;

  always_comb begin
    lz = X;
    for (int i = 0; i < X; i++) if (man_q[i]) lz = X - 1 - i;
    shl = lz;
    // Gradual underflow: never shift below emin, leaving a subnormal.
    if (!FLUSH && (lz > int'(exp_q) - 1)) shl = int'(exp_q) - 1;
    if (man_q[X]) begin
      norm_man = {1'b0, man_q[X:2], man_q[1] | man_q[0]};
      norm_exp = exp_q + EW'(1);
    end else begin
      norm_man = man_q << shl;
      norm_exp = exp_q - EW'(shl);
    end
  end

  logic                 g, rs, lsb, inc;
  logic [MAN_W+1:0]     rounded;
  logic [X:0]           round_man;
  logic signed [EW-1:0] round_exp;

  always_comb begin
    lsb = man_q[3];
    g   = man_q[2];
    rs  = man_q[1] | man_q[0];
    case (rm_q)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign_q & (g | rs);
      RUP:     inc = !sign_q & (g | rs);
      RMM:     inc = g;
      default: inc = g & (rs | lsb);           // RNE: ties to even
    endcase
    rounded = {1'b0, man_q[X-1:3]} + (MAN_W+2)'(inc);
    if (rounded[MAN_W+1]) begin
      round_man = {1'b0, rounded[MAN_W+1:1], 3'b000};
      round_exp = exp_q + EW'(1);
    end else begin
      round_man = {1'b0, rounded[MAN_W:0], 3'b000};
      round_exp = exp_q;
    end
  end

  logic [W-1:0] pack_result;
  logic [4:0]   pack_flags;
  logic         to_inf;

  always_comb begin
    to_inf      = (rm_q == RNE) || (rm_q == RMM) ||
                  ((rm_q == RUP) && !sign_q) || ((rm_q == RDN) && sign_q);
    pack_result = {sign_q, (man_q[X-1] ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}}), man_q[X-2:3]};
    // A subnormal (exp field 0) result is tiny; it underflows only if inexact.
    pack_flags  = {3'b000, !man_q[X-1] && nx_q, nx_q};
    if (zero_q) begin
      pack_result = {rm_q == RDN, {(W-1){1'b0}}};
      pack_flags  = 5'b00000;
    end else if (exp_q > EMAX) begin
      pack_flags  = 5'b00101;
      pack_result = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                           : {sign_q, EXP_W'((2 ** EXP_W) - 2), {MAN_W{1'b1}}};
    end else if (FLUSH && (exp_q < EMIN)) begin
      pack_result = {sign_q, {(W-1){1'b0}}};
      pack_flags  = 5'b00011;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (i_request) state_next = S_SPECIAL;
      S_SPECIAL: state_next = spec_hit ? S_DONE : S_ALIGN;
      S_ALIGN:   state_next = S_ADD;
      S_ADD:     state_next = S_NORM;
      S_NORM:    state_next = S_ROUND;
      S_ROUND:   state_next = S_PACK;
      S_PACK:    state_next = S_DONE;
      S_DONE:    if (!i_request) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_next = (state == S_DONE) && i_request;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_a      <= '0;
      op_b      <= '0;
      rm_q      <= RNE;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      zero_q    <= 1'b0;
      nx_q      <= 1'b0;
      exp_q     <= '0;
      man_q     <= '0;
      small_q   <= '0;
      shift_q   <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= ready_next;
      case (state)
        S_IDLE: if (i_request) begin
          op_a <= i_op1;
          op_b <= {i_op2[W-1] ^ i_sub, i_op2[W-2:0]};
          rm_q <= (i_rm > 3'd4) ? RNE : rm_t'(i_rm);
        end
        S_SPECIAL: begin
          if (spec_hit) begin
            result_q <= spec_result;
            flags_q  <= {spec_nv, 4'b0000};
          end
          sign_q    <= swap ? sb : sa;
          eff_sub_q <= sa ^ sb;
          exp_q     <= $signed({2'b00, big_exp});
          man_q     <= {1'b0, big_man};
          small_q   <= small_man;
          shift_q   <= shift_sat;
        end
        S_ALIGN: small_q <= aligned;
        S_ADD: begin
          man_q  <= sum;
          zero_q <= (sum == '0);
        end
        S_NORM: begin
          man_q <= norm_man;
          exp_q <= norm_exp;
        end
        S_ROUND: begin
          man_q <= round_man;
          exp_q <= round_exp;
          nx_q  <= g | rs;
        end
        S_PACK: begin
          result_q <= pack_result;
          flags_q  <= pack_flags;
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_cpu_fpu_addsub_param.sv
// -----------------------------------------------------------------------------
// tb_cpu_fpu_addsub_param
//   Directed self-checking bench for cpu_fpu_addsub_param (EXP_W=8, MAN_W=23).
//   Each operation checks latency from the capture edge, result, flags, that
//   o_ready stays held while requested, and that it drops after release.
// -----------------------------------------------------------------------------
module tb_cpu_fpu_addsub_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        request = 1'b0;
  logic        sub = 1'b0;
  logic [2:0]  rm = 3'd0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        ready;
  logic [31:0] result;
  logic [4:0]  flags;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_request (request),
    .i_sub     (sub),
    .i_rm      (rm),
    .i_op1     (op1),
    .i_op2     (op2),
    .o_ready   (ready),
    .o_result  (result),
    .o_flags   (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full handshake; inputs are scrambled right after capture to show they
  // are ignored once taken.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [2:0] mode,
                        input logic [31:0] exp_res, input logic [4:0] exp_flags,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    op1 = a; op2 = b; sub = s; rm = mode; request = 1'b1;
    @(posedge clk);
    #1;
    op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678; sub = ~s; rm = 3'd3;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, {32'h0, result}, {32'h0, exp_res});
    check({tag, " flags"}, {59'h0, flags}, {59'h0, exp_flags});
    @(posedge clk);
    #1;
    check({tag, " ready held"}, {63'h0, ready}, 64'd1);
    @(negedge clk);
    request = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready drop"}, {63'h0, ready}, 64'd0);
  endtask

  initial begin
    #12;
    check("reset ready", {63'h0, ready}, 64'd0);
    check("reset result", {32'h0, result}, 64'd0);
    check("reset flags", {59'h0, flags}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal path
    run_op("1+2 rne",       32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'b00000, 7);
    run_op("1-1 rne",       32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 5'b00000, 7);
    run_op("1-1 rdn",       32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 5'b00000, 7);
    run_op("2-1 rne",       32'h40000000, 32'h3F800000, 1'b1, 3'd0, 32'h3F800000, 5'b00000, 7);
    run_op("1-1.5 rne",     32'h3F800000, 32'h3FC00000, 1'b1, 3'd0, 32'hBF000000, 5'b00000, 7);
    run_op("max+max rne",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 5'b00101, 7);
    run_op("max+max rtz",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 5'b00101, 7);
    run_op("tie rne",       32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 5'b00001, 7);
    run_op("tie rup",       32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 5'b00001, 7);
    run_op("tie rmm",       32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 5'b00001, 7);
    run_op("tie rm7",       32'h3F800000, 32'h33800000, 1'b0, 3'd7, 32'h3F800000, 5'b00001, 7);
    run_op("neg tie rdn",   32'hBF800000, 32'hB3800000, 1'b0, 3'd2, 32'hBF800001, 5'b00001, 7);
    run_op("neg tie rtz",   32'hBF800000, 32'hB3800000, 1'b0, 3'd1, 32'hBF800000, 5'b00001, 7);
`ifdef FPU_ADDSUB_FLUSH_DENORM_EN
    run_op("denorm add",    32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000000, 5'b00000, 2);
    run_op("minnorm-denorm",32'h00800000, 32'h00000001, 1'b1, 3'd0, 32'h00800000, 5'b00000, 2);
`else
    run_op("denorm add",    32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000002, 5'b00000, 7);
    run_op("minnorm-denorm",32'h00800000, 32'h00000001, 1'b1, 3'd0, 32'h007FFFFF, 5'b00000, 7);
`endif

    // Special path
    run_op("inf-inf",       32'h7F800000, 32'hFF800000, 1'b0, 3'd0, 32'h7FC00000, 5'b10000, 2);
    run_op("snan+1",        32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'b10000, 2);
    run_op("qnan+1",        32'h7FC00001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'b00000, 2);
    run_op("inf+1",         32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 32'h7F800000, 5'b00000, 2);
    run_op("0+1.5",         32'h00000000, 32'h3FC00000, 1'b0, 3'd0, 32'h3FC00000, 5'b00000, 2);
    run_op("-0+-0",         32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 5'b00000, 2);
    run_op("+0+-0 rne",     32'h00000000, 32'h80000000, 1'b0, 3'd0, 32'h00000000, 5'b00000, 2);
    run_op("+0+-0 rdn",     32'h00000000, 32'h80000000, 1'b0, 3'd2, 32'h80000000, 5'b00000, 2);

    // Reset while the operation sits in ALIGN
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h3F800000; sub = 1'b0; rm = 3'd0; request = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort ready", {63'h0, ready}, 64'd0);
    check("abort result", {32'h0, result}, 64'd0);
    check("abort flags", {59'h0, flags}, 64'd0);
    @(negedge clk);
    request = 1'b0;
    rst_n = 1'b1;
    run_op("after reset",   32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 5'b00000, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
